// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared defaults, mode constants and sizing helper for the sequence detector
package seq_det_pkg;

   localparam int DEF_MAX_LEN = 8;
   localparam int DEF_CNT_W   = 8;

   localparam logic OVERLAP     = 1'b1;
   localparam logic NON_OVERLAP = 1'b0;

   function automatic int len_width(input int max_len);
      return $clog2(max_len + 1);
   endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter
   import seq_det_pkg::*;
#(
   parameter int W = DEF_CNT_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] count
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/seq_detect_prog.sv
// rtl/seq_detect_prog.sv - programmable serial pattern detector with overlap control and match counter
module seq_detect_prog
   import seq_det_pkg::*;
#(
   parameter  int MAX_LEN = DEF_MAX_LEN,
   parameter  int CNT_W   = DEF_CNT_W,
   localparam int LEN_W   = len_width(MAX_LEN)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [LEN_W-1:0]   cfg_len,
   input  logic               cfg_overlap,
   input  logic               in_valid,
   input  logic               in_bit,
   output logic               match,
   output logic [CNT_W-1:0]   match_count,
   output logic               cfg_err
);

   logic [MAX_LEN-1:0] pat_q;
   logic [MAX_LEN-1:0] hist_q;
   logic [MAX_LEN-1:0] hist_nxt;
   logic [MAX_LEN-1:0] mask;
   logic [LEN_W-1:0]   len_q;
   logic [LEN_W-1:0]   fill_q;
   logic [LEN_W-1:0]   fill_nxt;
   logic               ovl_q;
   logic               len_bad;
   logic               hit;

   assign len_bad = (len_q < LEN_W'(2)) || (len_q > LEN_W'(MAX_LEN));
   assign cfg_err = len_bad;

   // Shifting all-ones by len leaves zeros in the low len bits; a shift of MAX_LEN yields a full mask.
   always_comb begin
      mask     = ~({MAX_LEN{1'b1}} << len_q);
      hist_nxt = {hist_q[MAX_LEN-2:0], in_bit};
      fill_nxt = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + 1'b1;
      hit      = in_valid && !cfg_load && !len_bad && (fill_nxt >= len_q)
                 && (((hist_nxt ^ pat_q) & mask) == '0);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pat_q  <= '0;
         len_q  <= LEN_W'(4);
         ovl_q  <= OVERLAP;
         hist_q <= '0;
         fill_q <= '0;
         match  <= 1'b0;
      end else if (cfg_load) begin
         pat_q  <= cfg_pattern;
         len_q  <= cfg_len;
         ovl_q  <= cfg_overlap;
         hist_q <= '0;
         fill_q <= '0;
         match  <= 1'b0;
      end else if (in_valid) begin
         hist_q <= hist_nxt;
         // Non-overlapping mode restarts the search after every hit.
         fill_q <= (hit && (ovl_q == NON_OVERLAP)) ? '0 : fill_nxt;
         match  <= hit;
      end else begin
         match  <= 1'b0;
      end
   end

   sat_counter #(
      .W(CNT_W)
   ) u_match_cnt (
      .clk  (clk),
      .reset(reset),
      .clear(cfg_load),
      .inc  (hit),
      .count(match_count)
   );

endmodule

// File: tb/tb_seq_detect_prog.sv
// tb/tb_seq_detect_prog.sv - self-checking bench for seq_detect_prog against a bit-queue reference model
module tb_seq_detect_prog;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_load;
   logic [7:0] cfg_pattern;
   logic [3:0] cfg_len;
   logic       cfg_overlap;
   logic       in_valid;
   logic       in_bit;
   logic       match;
   logic [7:0] match_count;
   logic       cfg_err;
   logic       match2;
   logic [1:0] match_count2;
   logic       cfg_err2;

   int passed = 0;
   int total  = 0;

   // reference model: the consumed bits since restart, most recent at the back
   bit       mq[$];
   bit [7:0] m_pat;
   int       m_len;
   bit       m_ovl;
   bit       m_err;
   int       m_cnt;
   int       m_cnt2;

   always #5 clk = ~clk;

   seq_detect_prog dut (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
      .match(match), .match_count(match_count), .cfg_err(cfg_err)
   );

   seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) dut2 (
      .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .in_valid(in_valid), .in_bit(in_bit),
      .match(match2), .match_count(match_count2), .cfg_err(cfg_err2)
   );

   task automatic model_load(input bit [7:0] p, input int l, input bit o);
      m_pat = p; m_len = l; m_ovl = o;
      m_err = (l < 2) || (l > 8);
      mq.delete();
      m_cnt = 0; m_cnt2 = 0;
   endtask

   task automatic model_consume(input bit b, output bit e);
      int n;
      bit ok;
      e = 1'b0;
      mq.push_back(b);
      if (mq.size() > 8) void'(mq.pop_front());
      n = mq.size();
      if (!m_err && n >= m_len) begin
         ok = 1'b1;
         for (int i = 0; i < m_len; i++)
            if (mq[n-m_len+i] != m_pat[m_len-1-i]) ok = 1'b0;
         if (ok) begin
            e = 1'b1;
            if (m_cnt < 255) m_cnt++;
            if (m_cnt2 < 3) m_cnt2++;
            if (!m_ovl) mq.delete();
         end
      end
   endtask

   task automatic do_load(input bit [7:0] p, input int l, input bit o);
      cfg_pattern = p; cfg_len = 4'(l); cfg_overlap = o; cfg_load = 1'b1;
      in_valid = 1'($urandom_range(0, 1)); in_bit = 1'($urandom_range(0, 1));
      @(posedge clk); @(negedge clk);
      cfg_load = 1'b0; in_valid = 1'b0;
      model_load(p, l, o);
   endtask

   task automatic step(input bit v, input bit b, output bit e);
      in_valid = v; in_bit = b;
      @(posedge clk); @(negedge clk);
      in_valid = 1'b0;
      e = 1'b0;
      if (v) model_consume(b, e);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      #2;
      total++;
      if (match !== 1'b0 || match_count !== 8'd0) $display("FAIL async_reset match=%b count=%0d want 0/0", match, match_count);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      model_load(8'h00, 4, 1'b1);
   endtask

   task automatic test_reset();
      bit e;
      total++;
      if (match !== 1'b0 || match_count !== 8'd0 || cfg_err !== 1'b0)
         $display("FAIL reset_state match=%b count=%0d err=%b want 0/0/0", match, match_count, cfg_err);
      else passed++;
      @(negedge clk);
      reset = 1'b0;
      model_load(8'h00, 4, 1'b1);
      // default latched pattern 0000, length 4: the fourth zero must hit
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, e);
         total++;
         if (match !== (i == 3)) $display("FAIL reset_default bit%0d match=%b want %b", i, match, (i == 3));
         else passed++;
      end
   endtask

   task automatic test_overlap();
      logic [6:0] s = 7'b0110110;
      logic [6:0] want = 7'b0001001;
      bit e;
      do_load(8'b0110, 4, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, s[6-i], e);
         total++;
         if (match !== want[6-i]) $display("FAIL overlap bit%0d match=%b want %b", i + 1, match, want[6-i]);
         else passed++;
      end
      total++;
      if (match_count !== 8'd2) $display("FAIL overlap_count got %0d want 2", match_count);
      else passed++;
   endtask

   task automatic test_nonoverlap();
      logic [6:0] s = 7'b0110110;
      logic [6:0] want = 7'b0001000;
      bit e;
      do_load(8'b0110, 4, 1'b0);
      for (int i = 0; i < 7; i++) begin
         step(1'b1, s[6-i], e);
         total++;
         if (match !== want[6-i]) $display("FAIL nonoverlap bit%0d match=%b want %b", i + 1, match, want[6-i]);
         else passed++;
      end
      total++;
      if (match_count !== 8'd1) $display("FAIL nonoverlap_count got %0d want 1", match_count);
      else passed++;
   endtask

   task automatic test_gaps();
      logic [6:0] v    = 7'b1100011;
      logic [6:0] b    = 7'b0110010;
      logic [6:0] want = 7'b0000001;
      bit e;
      do_load(8'b0110, 4, 1'b1);
      for (int i = 0; i < 7; i++) begin
         step(v[6-i], b[6-i], e);
         total++;
         if (match !== want[6-i]) $display("FAIL gaps step%0d match=%b want %b", i, match, want[6-i]);
         else passed++;
      end
      total++;
      if (match_count !== 8'd1) $display("FAIL gaps_count got %0d want 1", match_count);
      else passed++;
   endtask

   task automatic test_saturate();
      bit e;
      do_load(8'b11, 2, 1'b1);
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b1, e);
         total++;
         if (match2 !== (k >= 2) || match_count2 !== 2'((k - 1 > 3) ? 3 : k - 1))
            $display("FAIL saturate bit%0d match=%b count=%0d want %b/%0d", k, match2, match_count2,
                     (k >= 2), (k - 1 > 3) ? 3 : k - 1);
         else passed++;
      end
      total++;
      if (match_count !== 8'd7) $display("FAIL saturate_wide got %0d want 7", match_count);
      else passed++;
   endtask

   task automatic test_illegal_len();
      logic [2:0] s = 3'b101;
      bit e;
      bit seen;
      do_load(8'h00, 0, 1'b1);
      total++;
      if (cfg_err !== 1'b1) $display("FAIL len0_err got %b want 1", cfg_err);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 16; i++) begin
         step(1'b1, (i % 3) == 2 ? 1'b1 : 1'b0, e);
         if (match !== 1'b0 || match_count !== 8'd0) seen = 1'b1;
      end
      total++;
      if (seen) $display("FAIL len0_quiet match or count became nonzero, count=%0d want 0", match_count);
      else passed++;
      do_load(8'hff, 9, 1'b1);
      total++;
      if (cfg_err !== 1'b1) $display("FAIL len9_err got %b want 1", cfg_err);
      else passed++;
      do_load(8'b101, 3, 1'b1);
      total++;
      if (cfg_err !== 1'b0) $display("FAIL len3_err got %b want 0", cfg_err);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, s[2-i], e);
         total++;
         if (match !== (i == 2)) $display("FAIL len3 bit%0d match=%b want %b", i + 1, match, (i == 2));
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      logic [4:0] s = 5'b00110;
      bit e;
      // default pattern 0000: three zeros, reset, one zero must not complete it
      pulse_reset();
      for (int i = 0; i < 3; i++) step(1'b1, 1'b0, e);
      pulse_reset();
      step(1'b1, 1'b0, e);
      total++;
      if (match !== 1'b0) $display("FAIL reset_discard match=%b want 0", match);
      else passed++;
      do_load(8'b0110, 4, 1'b1);
      step(1'b1, 1'b0, e); step(1'b1, 1'b1, e); step(1'b1, 1'b1, e);
      pulse_reset();
      do_load(8'b0110, 4, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, s[4-i], e);
         total++;
         if (match !== (i == 4)) $display("FAIL reset_mid bit%0d match=%b want %b", i, match, (i == 4));
         else passed++;
      end
   endtask

   task automatic test_random();
      bit e;
      int l;
      for (int n = 0; n < 500; n++) begin
         e = 1'b0;
         if (n == 0 || $urandom_range(0, 29) == 0) begin
            l = ($urandom_range(0, 1) == 1) ? $urandom_range(2, 4) : $urandom_range(0, 15);
            do_load(8'($urandom), l, 1'($urandom_range(0, 1)));
         end else begin
            cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_overlap = 1'($urandom_range(0, 1));
            step(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), e);
         end
         total++;
         if (match !== e || match_count !== 8'(m_cnt) || match_count2 !== 2'(m_cnt2) || cfg_err !== m_err)
            $display("FAIL random n=%0d match=%b cnt=%0d cnt2=%0d err=%b want %b/%0d/%0d/%b",
                     n, match, match_count, match_count2, cfg_err, e, m_cnt, m_cnt2, m_err);
         else passed++;
      end
   endtask

   initial begin
      reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      in_valid = 1'b0; in_bit = 1'b0;
      repeat (2) @(negedge clk);
      test_reset();
      test_overlap();
      test_nonoverlap();
      test_gaps();
      test_saturate();
      test_illegal_len();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
